// File: rtl/hilo_mul_ctrl_if.sv
// EX-stage / multiplier / HI-LO signal bundle for the multiply controller.
// master is the controller side, slave is the pipeline-plus-multiplier side.
interface hilo_mul_ctrl_if;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic        flush;
    logic        stall_req;
    logic        mul_start;
    logic        mul_annul;
    logic        mul_signed;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic [63:0] mul_result;
    logic        mul_ready;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        hilo_we;

    modport master (
        input  ex_valid, ex_op, ex_rs_data, ex_rt_data, flush, mul_result, mul_ready,
        output stall_req, mul_start, mul_annul, mul_signed, mul_op1, mul_op2,
               hi_o, lo_o, hilo_we
    );

    modport slave (
        output ex_valid, ex_op, ex_rs_data, ex_rt_data, flush, mul_result, mul_ready,
        input  stall_req, mul_start, mul_annul, mul_signed, mul_op1, mul_op2,
               hi_o, lo_o, hilo_we
    );
endinterface

// File: rtl/hilo_mul_ctrl.sv
// Launches MULT/MULTU on the sequential multiplier, stalls EX until mul_ready, then writes HI/LO.
// MTHI/MTLO write at the end of EX with no stall; flush during a multiply annuls it for one cycle.
module hilo_mul_ctrl (
    input  logic            clk,
    input  logic            rst,
    hilo_mul_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;

    state_t state;
    logic   mul_req;

    assign mul_req = bus.ex_valid && !bus.flush &&
                     ((bus.ex_op == OP_MULT) || (bus.ex_op == OP_MULTU));

    // ABORT keeps the pipeline held so a request arriving behind the flush waits for IDLE.
    assign bus.stall_req = ((state == IDLE) && mul_req) || (state == BUSY) || (state == ABORT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            bus.hi_o       <= 32'd0;
            bus.lo_o       <= 32'd0;
            bus.mul_start  <= 1'b0;
            bus.mul_annul  <= 1'b0;
            bus.mul_signed <= 1'b0;
            bus.mul_op1    <= 32'd0;
            bus.mul_op2    <= 32'd0;
            bus.hilo_we    <= 1'b0;
        end else begin
            bus.hilo_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ex_valid && !bus.flush) begin
                        case (bus.ex_op)
                            OP_MULT, OP_MULTU: begin
                                bus.mul_op1    <= bus.ex_rs_data;
                                bus.mul_op2    <= bus.ex_rt_data;
                                bus.mul_signed <= (bus.ex_op == OP_MULT);
                                bus.mul_start  <= 1'b1;
                                state          <= BUSY;
                            end
                            OP_MTHI: begin
                                bus.hi_o    <= bus.ex_rs_data;
                                bus.hilo_we <= 1'b1;
                            end
                            OP_MTLO: begin
                                bus.lo_o    <= bus.ex_rs_data;
                                bus.hilo_we <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // Operands stay put: the multiplier re-reads them when it completes.
                    if (bus.flush) begin
                        bus.mul_start <= 1'b0;
                        bus.mul_annul <= 1'b1;
                        state         <= ABORT;
                    end else if (bus.mul_ready) begin
                        bus.hi_o      <= bus.mul_result[63:32];
                        bus.lo_o      <= bus.mul_result[31:0];
                        bus.hilo_we   <= 1'b1;
                        bus.mul_start <= 1'b0;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ABORT: begin
                    bus.mul_annul <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Directed bench for hilo_mul_ctrl with a behavioural multiplier that is ready 35 cycles after start.
module tb_hilo_mul_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hilo_mul_ctrl_if ifc ();

    hilo_mul_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Multiplier model: start seen at edge 2 gives mul_ready in cycle 36.
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_WAIT} mstate_t;
    mstate_t     m_state;
    logic [5:0]  m_cnt;
    logic [63:0] ea, eb;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= M_IDLE;
            m_cnt   <= 6'd0;
        end else if (ifc.mul_annul) begin
            m_state <= M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (ifc.mul_start) begin m_state <= M_RUN; m_cnt <= 6'd0; end
                M_RUN:  if (m_cnt == 6'd34) m_state <= M_WAIT; else m_cnt <= m_cnt + 6'd1;
                M_WAIT: if (!ifc.mul_start) m_state <= M_IDLE;
                default: m_state <= M_IDLE;
            endcase
        end
    end

    always_comb begin
        ea = {{32{ifc.mul_signed & ifc.mul_op1[31]}}, ifc.mul_op1};
        eb = {{32{ifc.mul_signed & ifc.mul_op2[31]}}, ifc.mul_op2};
    end
    assign ifc.mul_ready  = (m_state == M_RUN) && (m_cnt == 6'd34);
    assign ifc.mul_result = ifc.mul_ready ? ea * eb : 64'd0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic fl);
        ifc.ex_valid   = v;
        ifc.ex_op      = op;
        ifc.ex_rs_data = rs;
        ifc.ex_rt_data = rt;
        ifc.flush      = fl;
    endtask

    task automatic test_reset();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #2;
        checks++;
        if ({ifc.hi_o, ifc.lo_o, ifc.mul_op1, ifc.mul_op2} !== 128'd0) begin
            errors++; $display("FAIL reset_regs got=%h exp=0", {ifc.hi_o, ifc.lo_o, ifc.mul_op1, ifc.mul_op2});
        end
        checks++;
        if ({ifc.mul_start, ifc.mul_annul, ifc.mul_signed, ifc.hilo_we, ifc.stall_req} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl got=%b exp=00000",
                {ifc.mul_start, ifc.mul_annul, ifc.mul_signed, ifc.hilo_we, ifc.stall_req});
        end
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_mult_signed();
        drive(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        for (int c = 0; c <= 37; c++) begin
            @(negedge clk);
            checks++;
            if (ifc.stall_req !== (c <= 36)) begin
                errors++; $display("FAIL mult_stall c=%0d got=%b exp=%b", c, ifc.stall_req, c <= 36);
            end
            checks++;
            if (ifc.hilo_we !== (c == 37)) begin
                errors++; $display("FAIL mult_we c=%0d got=%b exp=%b", c, ifc.hilo_we, c == 37);
            end
            if (c == 1) begin
                checks++;
                if ({ifc.mul_start, ifc.mul_signed} !== 2'b11) begin
                    errors++; $display("FAIL mult_launch got=%b exp=11", {ifc.mul_start, ifc.mul_signed});
                end
            end
            if (c == 37) begin
                checks++;
                if ({ifc.hi_o, ifc.lo_o} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
                    errors++; $display("FAIL mult_hilo got=%h exp=FFFFFFFFFFFFFFF1", {ifc.hi_o, ifc.lo_o});
                end
            end
            next_cycle();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        next_cycle();
    endtask

    task automatic test_multu();
        drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int c = 0; c <= 37; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 36) begin
                checks++;
                if ({ifc.mul_op1, ifc.mul_op2, ifc.mul_signed} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b0}) begin
                    errors++; $display("FAIL multu_ops c=%0d got=%h_%h s=%b exp=FFFFFFFF_FFFFFFFF s=0",
                        c, ifc.mul_op1, ifc.mul_op2, ifc.mul_signed);
                end
            end
            if (c == 37) begin
                checks++;
                if ({ifc.hilo_we, ifc.hi_o, ifc.lo_o} !== {1'b1, 64'hFFFF_FFFE_0000_0001}) begin
                    errors++; $display("FAIL multu_hilo got=%b_%h exp=1_FFFFFFFE00000001",
                        ifc.hilo_we, {ifc.hi_o, ifc.lo_o});
                end
            end
            next_cycle();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic seen;
        drive(1'b1, 3'd1, 32'h7FFF_FFFF, 32'd2, 1'b0);
        for (int c = 0; c <= 37; c++) begin
            @(negedge clk);
            if (c == 37) begin
                checks++;
                if ({ifc.hi_o, ifc.lo_o} !== 64'h0000_0000_FFFF_FFFE) begin
                    errors++; $display("FAIL b2b_mult got=%h exp=00000000FFFFFFFE", {ifc.hi_o, ifc.lo_o});
                end
            end
            next_cycle();
        end
        drive(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (ifc.stall_req !== 1'b0) begin
            errors++; $display("FAIL mtlo_nostall got=%b exp=0", ifc.stall_req);
        end
        next_cycle();
        drive(1'b1, 3'd2, 32'd2, 32'd3, 1'b0);
        @(negedge clk);
        checks++;
        if ({ifc.hilo_we, ifc.hi_o, ifc.lo_o, ifc.stall_req} !== {1'b1, 64'h0000_0000_1234_5678, 1'b1}) begin
            errors++; $display("FAIL mtlo_write got=%b_%h_%b exp=1_0000000012345678_1",
                ifc.hilo_we, {ifc.hi_o, ifc.lo_o}, ifc.stall_req);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({ifc.mul_start, ifc.mul_op1, ifc.mul_op2} !== {1'b1, 32'd2, 32'd3}) begin
            errors++; $display("FAIL b2b_launch got=%b_%h_%h exp=1_00000002_00000003",
                ifc.mul_start, ifc.mul_op1, ifc.mul_op2);
        end
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ifc.hilo_we) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || {ifc.hi_o, ifc.lo_o} !== 64'd6) begin
            errors++; $display("FAIL b2b_result seen=%b got=%h exp=0000000000000006", seen, {ifc.hi_o, ifc.lo_o});
        end
        next_cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        next_cycle();
    endtask

    task automatic test_flush_abort();
        logic seen;
        drive(1'b1, 3'd1, 32'd7, 32'd9, 1'b0);
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            checks++;
            if ({ifc.stall_req, ifc.mul_annul} !== 2'b10) begin
                errors++; $display("FAIL abort_pre c=%0d got=%b exp=10", c, {ifc.stall_req, ifc.mul_annul});
            end
            next_cycle();
        end
        ifc.flush = 1'b1;
        next_cycle();
        drive(1'b1, 3'd2, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        checks++;
        if ({ifc.mul_annul, ifc.mul_start, ifc.stall_req, ifc.hilo_we} !== 4'b1010) begin
            errors++; $display("FAIL abort_annul got=%b exp=1010",
                {ifc.mul_annul, ifc.mul_start, ifc.stall_req, ifc.hilo_we});
        end
        checks++;
        if ({ifc.hi_o, ifc.lo_o} !== 64'd6) begin
            errors++; $display("FAIL abort_hilo got=%h exp=0000000000000006", {ifc.hi_o, ifc.lo_o});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({ifc.mul_annul, ifc.mul_start, ifc.stall_req, m_state == M_IDLE} !== 4'b0011) begin
            errors++; $display("FAIL abort_idle got=%b exp=0011",
                {ifc.mul_annul, ifc.mul_start, ifc.stall_req, m_state == M_IDLE});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({ifc.mul_start, ifc.mul_signed, ifc.mul_op1} !== {2'b10, 32'd3}) begin
            errors++; $display("FAIL abort_relaunch got=%b_%b_%h exp=1_0_00000003",
                ifc.mul_start, ifc.mul_signed, ifc.mul_op1);
        end
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ifc.hilo_we) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || {ifc.hi_o, ifc.lo_o} !== 64'd12) begin
            errors++; $display("FAIL abort_multu seen=%b got=%h exp=000000000000000C", seen, {ifc.hi_o, ifc.lo_o});
        end
        next_cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        next_cycle();
    endtask

    task automatic test_mthi_flush();
        drive(1'b1, 3'd3, 32'hA5A5_A5A5, 32'd0, 1'b0);
        next_cycle();
        drive(1'b1, 3'd3, 32'h1111_1111, 32'd0, 1'b1);
        @(negedge clk);
        checks++;
        if ({ifc.hilo_we, ifc.hi_o, ifc.stall_req} !== {1'b1, 32'hA5A5_A5A5, 1'b0}) begin
            errors++; $display("FAIL mthi_write got=%b_%h_%b exp=1_A5A5A5A5_0", ifc.hilo_we, ifc.hi_o, ifc.stall_req);
        end
        next_cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checks++;
        if ({ifc.hilo_we, ifc.hi_o, ifc.lo_o} !== {1'b0, 32'hA5A5_A5A5, 32'd12}) begin
            errors++; $display("FAIL mthi_flush got=%b_%h_%h exp=0_A5A5A5A5_0000000C",
                ifc.hilo_we, ifc.hi_o, ifc.lo_o);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'd1, 32'd100, 32'd200, 1'b0);
        for (int c = 0; c < 5; c++) next_cycle();
        @(negedge clk);
        checks++;
        if ({ifc.mul_start, ifc.stall_req} !== 2'b11) begin
            errors++; $display("FAIL rstmid_busy got=%b exp=11", {ifc.mul_start, ifc.stall_req});
        end
        #2;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if ({ifc.hi_o, ifc.lo_o, ifc.mul_op1, ifc.mul_op2} !== 128'd0) begin
            errors++; $display("FAIL rstmid_regs got=%h exp=0", {ifc.hi_o, ifc.lo_o, ifc.mul_op1, ifc.mul_op2});
        end
        checks++;
        if ({ifc.mul_start, ifc.mul_annul, ifc.mul_signed, ifc.hilo_we, ifc.stall_req} !== 5'b0) begin
            errors++; $display("FAIL rstmid_ctl got=%b exp=00000",
                {ifc.mul_start, ifc.mul_annul, ifc.mul_signed, ifc.hilo_we, ifc.stall_req});
        end
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({ifc.stall_req, ifc.mul_start} !== 2'b00) begin
            errors++; $display("FAIL rstmid_after got=%b exp=00", {ifc.stall_req, ifc.mul_start});
        end
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu();
        test_back_to_back();
        test_flush_abort();
        test_mthi_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hilo_mul_ctrl.md
# hilo_mul_ctrl

Execute-stage controller between the pipeline and the 32-bit sequential multiplier (mul_32). It accepts MULT/MULTU/MTHI/MTLO from EX and launches the multiplier with held operands. While the multiply runs it stalls the pipeline, then writes the 64-bit product into the architectural HI/LO registers. On a pipeline flush it aborts the multiply cleanly, leaving the multiplier idle.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX holds a valid instruction
- ex_op  in  3  0=none, 1=MULT, 2=MULTU, 3=MTHI, 4=MTLO, others=none
- ex_rs_data  in  32  rs operand / MTHI-MTLO source
- ex_rt_data  in  32  rt operand
- flush  in  1  kill the EX instruction this cycle
- stall_req  out  1  combinational request to hold IF/ID/EX
- mul_start  out  1  registered start to multiplier
- mul_annul  out  1  registered annul to multiplier
- mul_signed  out  1  registered, 1 for MULT
- mul_op1, mul_op2  out  32 each  registered operands
- mul_result  in  64  multiplier product
- mul_ready  in  1  multiplier result valid
- hi_o, lo_o  out  32 each  HI/LO register values
- hilo_we  out  1  one-cycle pulse, HI/LO written on the preceding edge

## Operation
- States: IDLE, BUSY, DONE, ABORT. Reset enters IDLE.
- Reset values: hi_o=0, lo_o=0, mul_start=0, mul_annul=0, mul_signed=0, mul_op1=0, mul_op2=0, hilo_we=0.
- IDLE, ex_valid, op MULT/MULTU, !flush:
  - mul_op1<=rs, mul_op2<=rt, mul_signed<=(op==MULT), mul_start<=1.
  - Next state: BUSY.
- IDLE, ex_valid, op MTHI (MTLO), !flush: hi_o (lo_o)<=rs, hilo_we<=1. State stays IDLE; no stall.
- IDLE with flush: no state change and no HI/LO write.
- BUSY, !flush, mul_ready=1:
  - hi_o<=mul_result[63:32], lo_o<=mul_result[31:0], hilo_we<=1, mul_start<=0.
  - Next state: DONE.
- BUSY, !flush, mul_ready=0: hold all outputs.
- BUSY with flush (overrides mul_ready): mul_start<=0, mul_annul<=1, HI/LO unchanged, next state ABORT.
- ABORT: mul_annul<=0, next state IDLE. Any request present is ignored this cycle and stalled.
- DONE: unconditional next state IDLE. Pipeline advances past the multiply on this edge.
- mul_op1, mul_op2 and mul_signed stay unchanged from launch until the next launch. The multiplier samples operands again at completion, so they must stay stable.
- hilo_we clears every cycle unless set above.

## Timing
- stall_req = (IDLE & ex_valid & op∈{MULT,MULTU} & !flush) | BUSY | ABORT. Low in DONE.
- Launch: the request is in EX in cycle 0. mul_start goes high at edge 1.
- Stall length: stall_req stays high from cycle 0 through the cycle in which mul_ready is first seen. HI/LO update on the following edge.
- With mul_32 (ready at edge 36), stall_req is high for cycles 0–36. HI/LO and hilo_we update at edge 37. stall_req is low in cycle 37.
- Abort sequence:
  - mul_annul is high for exactly one cycle with mul_start=0.
  - That returns the multiplier to idle from any of its states.
  - The multiplier is idle before the controller re-enters IDLE.
- Back-to-back multiplies: the second launches from IDLE, one cycle after DONE.
- MTHI/MTLO: write at the end of the EX cycle. A read of hi_o/lo_o in the next cycle sees the new value.
- Reset asserted mid-multiply: all registers clear immediately and mul_start drops. The multiplier's own reset is wired to the same source.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=5:
  - stall_req high cycles 0–36; mul_signed=1.
  - Edge 37: hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1, hilo_we pulse.
- MULTU rs=rt=0xFFFFFFFF: hi_o=0xFFFFFFFE, lo_o=0x00000001. mul_op1/op2 stable throughout BUSY.
- MULT 0x7FFFFFFF×2, then MTLO rs=0x12345678 the cycle after DONE: hi_o=0, lo_o=0x12345678, with no stall on the MTLO.
- flush in cycle 10 of a MULT:
  - mul_annul high exactly one cycle, HI/LO unchanged, ABORT then IDLE.
  - A following MULTU 3×4 gives lo_o=12, hi_o=0.
- MTHI with flush in the same cycle: hi_o unchanged, hilo_we stays 0.
- rst low during BUSY: outputs at reset values that cycle, state IDLE, stall_req=0 with no new request.
